// File: rtl/mac_output_serializer.sv
// Splits 16-bit MAC results (plus overflow flag) into a low-then-high byte stream behind a small FIFO.
// Latency: first byte valid the cycle after the push. Backpressure: bytes hold on ready_in=0; full pushes are dropped (sticky drop_out).
// Optional parity output enabled by defining OUT_PARITY_EN.
module mac_output_serializer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] result_in,
    input  logic        overflow_in,
    input  logic        result_valid_in,
    input  logic        ready_in,
    output logic [7:0]  data_out,
    output logic        byte_valid_out,
    output logic        byte_hi_out,
    output logic        ovf_out,
    output logic        full_out,
    output logic        drop_out
`ifdef OUT_PARITY_EN
    ,
    output logic        parity_out
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

    state_t            state, state_nxt;
    logic [16:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CNT_W-1:0]  count, count_nxt, count_after_pop;
    logic [16:0]       head_nxt;
    logic              hs, pop, push, drop;
    logic [7:0]        data_nxt;
    logic              ovf_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign hs   = byte_valid_out & ready_in;
    assign pop  = hs && (state == SEND_HI);
    assign push = result_valid_in && ((count != DEPTH_C) || pop);
    assign drop = result_valid_in && !push;

    always_comb begin
        count_after_pop = pop ? count - CNT_W'(1) : count;
        count_nxt       = count_after_pop + (push ? CNT_W'(1) : '0);
        rd_ptr_nxt      = pop  ? ptr_inc(rd_ptr) : rd_ptr;
        wr_ptr_nxt      = push ? ptr_inc(wr_ptr) : wr_ptr;
        // A word pushed into a FIFO that is empty after this edge's pop becomes the head directly.
        head_nxt        = (count_after_pop == '0) ? {overflow_in, result_in} : mem[rd_ptr_nxt];
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = 8'h00;
        ovf_nxt   = 1'b0;
        case (state)
            IDLE:    if (push) state_nxt = SEND_LO;
            SEND_LO: if (hs)   state_nxt = SEND_HI;
            SEND_HI: if (hs)   state_nxt = ((count_after_pop != '0) || push) ? SEND_LO : IDLE;
            default:           state_nxt = IDLE;
        endcase
        case (state_nxt)
            SEND_LO: begin
                data_nxt = head_nxt[7:0];
                ovf_nxt  = head_nxt[16];
            end
            SEND_HI: begin
                data_nxt = head_nxt[15:8];
                ovf_nxt  = head_nxt[16];
            end
            default: begin
                data_nxt = 8'h00;
                ovf_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {overflow_in, result_in};
    end

    // Outputs are registered from next-state values so they never see inputs combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            data_out       <= 8'h00;
            byte_valid_out <= 1'b0;
            byte_hi_out    <= 1'b0;
            ovf_out        <= 1'b0;
            full_out       <= 1'b0;
            drop_out       <= 1'b0;
`ifdef OUT_PARITY_EN
            parity_out     <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            rd_ptr         <= rd_ptr_nxt;
            wr_ptr         <= wr_ptr_nxt;
            count          <= count_nxt;
            data_out       <= data_nxt;
            byte_valid_out <= (state_nxt != IDLE);
            byte_hi_out    <= (state_nxt == SEND_HI);
            ovf_out        <= ovf_nxt;
            full_out       <= (count_nxt == DEPTH_C);
            drop_out       <= drop_out | drop;
`ifdef OUT_PARITY_EN
            parity_out     <= ^{data_nxt, ovf_nxt};
`endif
        end
    end

endmodule

// File: tb/tb_mac_output_serializer.sv
// Directed bench for mac_output_serializer with a byte-stream scoreboard.
module tb_mac_output_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] result_in;
    logic        overflow_in;
    logic        result_valid_in;
    logic        ready_in;
    logic [7:0]  data_out;
    logic        byte_valid_out;
    logic        byte_hi_out;
    logic        ovf_out;
    logic        full_out;
    logic        drop_out;
`ifdef OUT_PARITY_EN
    logic        parity_out;
`endif

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];   // {ovf, hi, byte}
    logic [9:0] mon_e;

    always #5 clk = ~clk;

    mac_output_serializer #(.FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .result_in       (result_in),
        .overflow_in     (overflow_in),
        .result_valid_in (result_valid_in),
        .ready_in        (ready_in),
        .data_out        (data_out),
        .byte_valid_out  (byte_valid_out),
        .byte_hi_out     (byte_hi_out),
        .ovf_out         (ovf_out),
        .full_out        (full_out),
        .drop_out        (drop_out)
`ifdef OUT_PARITY_EN
        ,
        .parity_out      (parity_out)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && byte_valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {22'b0, ovf_out, byte_hi_out, data_out}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("stream", {22'b0, ovf_out, byte_hi_out, data_out}, {22'b0, mon_e});
`ifdef OUT_PARITY_EN
                chk("stream_parity", {31'b0, parity_out}, {31'b0, ^{mon_e[9], mon_e[7:0]}});
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [15:0] w, input logic o, input logic accept);
        result_in       = w;
        overflow_in     = o;
        result_valid_in = 1'b1;
        if (accept) begin
            exp_q.push_back({o, 1'b0, w[7:0]});
            exp_q.push_back({o, 1'b1, w[15:8]});
        end
        step();
        result_valid_in = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        logic p;
        p = 1'b0;
`ifdef OUT_PARITY_EN
        p = parity_out;
`endif
        return {17'b0, p, data_out, byte_valid_out, byte_hi_out, ovf_out, full_out, drop_out};
    endfunction

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk(tag, all_outs(), 32'h0);
        exp_q.delete();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; result_in = '0; overflow_in = 1'b0; result_valid_in = 1'b0; ready_in = 1'b0;
        step();
        step();
        chk("reset_outputs", all_outs(), 32'h0);
        rst = 1'b0;
        step();

        // Basic word, consumer always ready.
        ready_in = 1'b1;
        do_push(16'hA55A, 1'b0, 1'b1);
        chk("a55a_lo", {byte_valid_out, byte_hi_out, data_out}, {2'b10, 8'h5A});
        step();
        chk("a55a_hi", {byte_valid_out, byte_hi_out, data_out}, {2'b11, 8'hA5});
        step();
        chk("a55a_idle", {byte_valid_out, byte_hi_out, data_out}, {2'b00, 8'h00});

        // Stall: low byte and ovf hold while ready_in is low.
        ready_in = 1'b0;
        do_push(16'h1234, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {byte_valid_out, byte_hi_out, ovf_out, data_out}, {3'b101, 8'h34});
            step();
        end
        ready_in = 1'b1;
        step();
        chk("stall_hi", {byte_valid_out, byte_hi_out, ovf_out, data_out}, {3'b111, 8'h12});
        step();
        chk("stall_idle", {byte_valid_out, ovf_out}, 32'd0);

        // Overfill a depth-2 FIFO.
        do_reset("reset_before_full");
        ready_in = 1'b0;
        do_push(16'h0001, 1'b0, 1'b1);
        do_push(16'h0002, 1'b0, 1'b1);
        chk("full_no_drop", {full_out, drop_out}, 32'b10);
        do_push(16'h0003, 1'b0, 1'b0);
        chk("full_drop", {full_out, drop_out}, 32'b11);
        ready_in = 1'b1;
        drain("drain_full");
        chk("after_drain", {byte_valid_out, full_out, drop_out}, 32'b001);

        // Push into a full FIFO on the same edge as the high-byte pop.
        do_reset("reset_before_sim");
        ready_in = 1'b0;
        do_push(16'h0011, 1'b0, 1'b1);
        do_push(16'h0022, 1'b0, 1'b1);
        ready_in = 1'b1;
        step();
        chk("sim_pre_hi", {byte_hi_out, data_out}, {1'b1, 8'h00});
        do_push(16'hBEEF, 1'b0, 1'b1);
        chk("sim_no_drop", {full_out, drop_out}, 32'b10);
        chk("sim_next_lo", {byte_valid_out, byte_hi_out, data_out}, {2'b10, 8'h22});
        drain("drain_sim");
        chk("sim_drop_final", {31'b0, drop_out}, 32'd0);

        // Reset in the middle of a word.
        do_reset("reset_before_mid");
        ready_in = 1'b1;
        do_push(16'hCAFE, 1'b0, 1'b1);
        step();
        chk("mid_hi", {byte_hi_out, data_out}, {1'b1, 8'hCA});
        rst = 1'b1;
        #1;
        chk("mid_reset_async", all_outs(), 32'h0);
        exp_q.delete();
        step();
        rst = 1'b0;
        chk("mid_reset_held", all_outs(), 32'h0);
        do_push(16'h0F0F, 1'b0, 1'b1);
        chk("post_reset_lo", {byte_valid_out, byte_hi_out, data_out}, {2'b10, 8'h0F});
        drain("drain_post_reset");

`ifdef OUT_PARITY_EN
        do_reset("reset_before_parity");
        ready_in = 1'b1;
        do_push(16'h0700, 1'b1, 1'b1);
        chk("parity_lo", {parity_out, data_out}, {1'b1, 8'h00});
        step();
        chk("parity_hi", {parity_out, data_out}, {1'b0, 8'h07});
        drain("drain_parity");
`endif

        step();
        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
